uart_rx_sipo: RTL and testbench
===============================

UART_RX_SIPO -- requirements
Module: uart_rx_sipo

Interface
REQ-001 Parameter OVERSAMPLE, default 16: number of baud_tick strobes per serial bit.
REQ-002 Parameter FRAME_BITS, default 11: bits per frame (start, 8 data, parity, stop).
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 baud_tick  input  1  one-clock oversample strobe at OVERSAMPLE x baud rate.
REQ-006 rx_serial  input  1  asynchronous serial line; idles high; LSB first.
REQ-007 data_parll  output  11  captured frame: [0]=start, [8:1]=data d0..d7, [9]=parity, [10]=stop.
REQ-008 done_flag  output  1  one-cycle pulse; data_parll updated this cycle.
REQ-009 active_flag  output  1  high while a frame is being received.
REQ-010 frame_err  output  1  one-cycle pulse, coincident with done_flag, when the sampled stop bit is 0.

Function
REQ-011 rx_serial SHALL pass a 2-flop synchronizer before use; synchronizer flops reset to 1.
REQ-012 The FSM SHALL have states IDLE, START, SHIFT, DONE.
REQ-013 tick_cnt (4 bits) and bit_idx (4 bits) SHALL advance only on cycles with baud_tick=1.
REQ-014 IDLE: on a baud_tick with the synced line at 0, the FSM SHALL enter START with tick_cnt=0. This tick is the detect tick.
REQ-015 Sampling rule: bit k (0..10) SHALL be sampled on the (16k+8)th baud_tick after the detect tick (mid-bit).
REQ-016 START: at the start-bit sample point, a synced 1 SHALL return the FSM to IDLE with no output (glitch reject). A synced 0 SHALL store bit 0, set bit_idx=1 and enter SHIFT.
REQ-017 SHIFT: at each sample point the synced line SHALL be stored at position bit_idx, then bit_idx increments. After bit 10 is stored, the FSM SHALL enter DONE.
REQ-018 DONE: this state SHALL last exactly one clock. It loads data_parll from the shift register, pulses done_flag, pulses frame_err if bit 10 = 0, and returns to IDLE.
REQ-019 Latency: done_flag SHALL assert the clock after the 168th baud_tick following the detect tick.
REQ-020 data_parll SHALL hold its value between done pulses. It SHALL NOT change on glitch reject.
REQ-021 active_flag SHALL be 1 in START, SHIFT and DONE, and 0 in IDLE.
REQ-022 Parity SHALL be captured, not checked; checking is the downstream deframer's job.
REQ-023 A new start SHALL be detectable from the first baud_tick after return to IDLE. Back-to-back frames with no idle gap SHALL be received.
REQ-024 baud_tick held high continuously SHALL be handled as a tick every clock.

Reset
REQ-025 While reset=1 on a clock edge: FSM=IDLE, tick_cnt=0, bit_idx=0, shift register=11'h7FF, data_parll=11'h7FF, done_flag=0, active_flag=0, frame_err=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame: no done_flag, and data_parll keeps its reset value.

Structure
REQ-027 Package uart_pkg SHALL hold OVERSAMPLE, FRAME_BITS, IDLE_LINE=1'b1 and the FSM state typedef; the deframer shares it.
REQ-028 The synchronizer SHALL be the sub-module sync_2ff (1-bit, reset value parameterised). All other logic is flat.

Verification
REQ-029 Reset: assert reset 3 clocks -> data_parll=11'h7FF; done_flag, active_flag and frame_err = 0.
REQ-030 Frame: 16x ticks; send start 0, data 0xA5 LSB first, parity 0, stop 1 -> data_parll=11'h54A, done_flag for exactly 1 clock, 168 ticks after detect, frame_err=0.
REQ-031 Glitch: line low for 4 ticks, then high -> no done_flag; active_flag returns to 0 after the 8th tick; data_parll unchanged.
REQ-032 Framing error: 0x3C, parity 0, stop 0 -> data_parll=11'h078, done_flag=1 and frame_err=1 in the same cycle.
REQ-033 Back-to-back: 0x00 (parity 0) then 0xFF (parity 0) with zero idle bits -> two done pulses; data_parll=11'h400, then 11'h5FE.
REQ-034 Reset mid-frame: reset during bit 4 -> active_flag=0 next clock, no done_flag; a following frame of 0x5A is received correctly, giving 11'h4B4.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART receive path
// (serial-to-parallel receiver and the downstream deframer).
//   OVERSAMPLE : baud_tick strobes per serial bit
//   FRAME_BITS : start + 8 data + parity + stop
//   IDLE_LINE  : level of an idle serial line
//   rx_state_t : receiver FSM encoding
package uart_pkg;

    localparam int   OVERSAMPLE = 16;
    localparam int   FRAME_BITS = 11;
    localparam logic IDLE_LINE  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
//   clock     : destination clock
//   reset     : synchronous, active-high; both flops load RESET_VAL
//   d         : asynchronous input
//   q         : synchronized output (two clocks of latency)
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // two-stage capture; the first stage may go metastable, the second settles it
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx_sipo.sv
// uart_rx_sipo: oversampling UART receiver that captures a whole frame
// (start, d0..d7, parity, stop) into a parallel word. Parity is captured
// only; checking it belongs to the deframer.
//   clock       : single clock, rising edge
//   reset       : synchronous, active-high
//   baud_tick   : one-clock strobe at OVERSAMPLE x baud rate
//   rx_serial   : asynchronous serial line, idles high, LSB first
//   data_parll  : captured frame [0]=start [8:1]=data [9]=parity [10]=stop
//   done_flag   : one-cycle pulse, data_parll updated in the same cycle
//   active_flag : high while a frame is in progress
//   frame_err   : one-cycle pulse with done_flag when the stop bit was 0
module uart_rx_sipo
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int FRAME_BITS = uart_pkg::FRAME_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  baud_tick,
    input  logic                  rx_serial,
    output logic [FRAME_BITS-1:0] data_parll,
    output logic                  done_flag,
    output logic                  active_flag,
    output logic                  frame_err
);

    // tick_cnt is zeroed on the detect tick, so the tick that samples
    // mid-bit is the one seen while the counter still reads half-1.
    localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] LAST_IDX  = 4'(FRAME_BITS - 1);

    rx_state_t             state_r;
    rx_state_t             next_state_s;
    logic [3:0]            tick_cnt_r;
    logic [3:0]            tick_cnt_nxt_s;
    logic [3:0]            tick_inc_s;
    logic [3:0]            bit_idx_r;
    logic [3:0]            bit_idx_nxt_s;
    logic [FRAME_BITS-1:0] shift_r;
    logic [FRAME_BITS-1:0] shift_nxt_s;
    logic [FRAME_BITS-1:0] data_parll_r;
    logic [FRAME_BITS-1:0] data_nxt_s;
    logic                  done_r;
    logic                  done_nxt_s;
    logic                  active_r;
    logic                  active_nxt_s;
    logic                  err_r;
    logic                  err_nxt_s;
    logic                  rx_sync_s;
    logic                  sample_s;

    sync_2ff #(
        .RESET_VAL (IDLE_LINE)
    ) u_rx_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx_serial),
        .q     (rx_sync_s)
    );

    assign sample_s   = baud_tick && (tick_cnt_r == MID_TICK);
    assign tick_inc_s = (tick_cnt_r == TICK_LAST) ? 4'd0 : (tick_cnt_r + 4'd1);

    // state and datapath registers; outputs are registered so they are
    // valid during the DONE cycle itself
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            tick_cnt_r   <= 4'd0;
            bit_idx_r    <= 4'd0;
            shift_r      <= {FRAME_BITS{1'b1}};
            data_parll_r <= {FRAME_BITS{1'b1}};
            done_r       <= 1'b0;
            active_r     <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            tick_cnt_r   <= tick_cnt_nxt_s;
            bit_idx_r    <= bit_idx_nxt_s;
            shift_r      <= shift_nxt_s;
            data_parll_r <= data_nxt_s;
            done_r       <= done_nxt_s;
            active_r     <= active_nxt_s;
            err_r        <= err_nxt_s;
        end
    end

    // next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (baud_tick && (rx_sync_s == 1'b0)) begin
                    next_state_s = START;
                end else begin
                    next_state_s = IDLE;
                end
            end
            START: begin
                // a line that is high again at mid start-bit was a glitch
                if (sample_s) begin
                    if (rx_sync_s) begin
                        next_state_s = IDLE;
                    end else begin
                        next_state_s = SHIFT;
                    end
                end else begin
                    next_state_s = START;
                end
            end
            SHIFT: begin
                if (sample_s && (bit_idx_r == LAST_IDX)) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // datapath and output next values
    always_comb begin
        tick_cnt_nxt_s = tick_cnt_r;
        bit_idx_nxt_s  = bit_idx_r;
        shift_nxt_s    = shift_r;
        case (state_r)
            IDLE: begin
                tick_cnt_nxt_s = 4'd0;
                bit_idx_nxt_s  = 4'd0;
            end
            START: begin
                if (baud_tick) begin
                    tick_cnt_nxt_s = tick_inc_s;
                end else begin
                    tick_cnt_nxt_s = tick_cnt_r;
                end
                if (sample_s && (rx_sync_s == 1'b0)) begin
                    shift_nxt_s[0] = 1'b0;
                    bit_idx_nxt_s  = 4'd1;
                end else begin
                    bit_idx_nxt_s  = bit_idx_r;
                end
            end
            SHIFT: begin
                if (baud_tick) begin
                    tick_cnt_nxt_s = tick_inc_s;
                end else begin
                    tick_cnt_nxt_s = tick_cnt_r;
                end
                if (sample_s) begin
                    shift_nxt_s[bit_idx_r] = rx_sync_s;
                    bit_idx_nxt_s          = bit_idx_r + 4'd1;
                end else begin
                    bit_idx_nxt_s          = bit_idx_r;
                end
            end
            DONE: begin
                tick_cnt_nxt_s = 4'd0;
                bit_idx_nxt_s  = 4'd0;
            end
            default: begin
                tick_cnt_nxt_s = 4'd0;
                bit_idx_nxt_s  = 4'd0;
            end
        endcase

        done_nxt_s   = (next_state_s == DONE);
        active_nxt_s = (next_state_s != IDLE);
        // the stop bit lands in shift_nxt_s on the same edge that enters DONE
        if (next_state_s == DONE) begin
            data_nxt_s = shift_nxt_s;
            err_nxt_s  = ~shift_nxt_s[FRAME_BITS-1];
        end else begin
            data_nxt_s = data_parll_r;
            err_nxt_s  = 1'b0;
        end
    end

    assign data_parll  = data_parll_r;
    assign done_flag   = done_r;
    assign active_flag = active_r;
    assign frame_err   = err_r;

endmodule

// File: tb/tb_uart_rx_sipo.sv
// tb_uart_rx_sipo: directed bench for uart_rx_sipo. One baud_tick every four
// clocks; each serial bit is held for 16 ticks starting at a tick boundary,
// so the first tick of the start bit is the detect tick (index 0).
module tb_uart_rx_sipo;

    logic        clock;
    logic        reset;
    logic        baud_tick;
    logic        rx_serial;
    logic [10:0] data_parll;
    logic        done_flag;
    logic        active_flag;
    logic        frame_err;

    int n_vec;
    int n_err;
    int done_count;

    uart_rx_sipo dut (
        .clock       (clock),
        .reset       (reset),
        .baud_tick   (baud_tick),
        .rx_serial   (rx_serial),
        .data_parll  (data_parll),
        .done_flag   (done_flag),
        .active_flag (active_flag),
        .frame_err   (frame_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // count every clock in which done_flag is high
    always @(negedge clock) begin
        if (done_flag === 1'b1) begin
            done_count <= done_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // three quiet clocks, then one clock with baud_tick high
    task automatic one_tick();
        repeat (3) @(posedge clock);
        #1 baud_tick = 1'b1;
        @(posedge clock);
        #1 baud_tick = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        rx_serial = 1'b1;
        for (int i = 0; i < n; i++) one_tick();
    endtask

    // drive 'word' LSB first for n_ticks ticks; when the 168th tick after
    // detect is reached, check the done pulse and captured word
    task automatic send_frame(input string tag, input logic [10:0] word, input int n_ticks,
                              input logic [10:0] exp_word, input logic exp_err);
        for (int idx = 0; idx < n_ticks; idx++) begin
            rx_serial = word[idx / 16];
            one_tick();
            if (idx == 167) chk({tag, "_pre_done"}, done_flag, 1'b0);
            if (idx == 168) begin
                chk({tag, "_done"}, done_flag, 1'b1);
                chk({tag, "_data"}, data_parll, exp_word);
                chk({tag, "_ferr"}, frame_err, exp_err);
                chk({tag, "_active"}, active_flag, 1'b1);
                @(posedge clock);
                #1;
                chk({tag, "_done_width"}, done_flag, 1'b0);
                chk({tag, "_ferr_width"}, frame_err, 1'b0);
                chk({tag, "_idle"}, active_flag, 1'b0);
                chk({tag, "_hold"}, data_parll, exp_word);
            end
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        baud_tick  = 1'b0;
        rx_serial  = 1'b1;

        // reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_data", data_parll, 11'h7FF);
        chk("rst_done", done_flag, 1'b0);
        chk("rst_active", active_flag, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        reset = 1'b0;
        idle_ticks(4);
        chk("idle_active", active_flag, 1'b0);

        // 0xA5, parity 0, stop 1
        send_frame("a5", {1'b1, 1'b0, 8'hA5, 1'b0}, 176, 11'h54A, 1'b0);
        idle_ticks(5);
        chk("a5_count", done_count, 1);

        // glitch: low for 4 ticks, then high; rejected at the 8th tick
        rx_serial = 1'b0;
        for (int i = 0; i < 4; i++) one_tick();
        rx_serial = 1'b1;
        for (int i = 4; i < 8; i++) one_tick();
        chk("glitch_active_t7", active_flag, 1'b1);
        one_tick();
        chk("glitch_active_t8", active_flag, 1'b0);
        idle_ticks(20);
        chk("glitch_count", done_count, 1);
        chk("glitch_data", data_parll, 11'h54A);

        // framing error: 0x3C, parity 0, stop 0
        send_frame("ferr", {1'b0, 1'b0, 8'h3C, 1'b0}, 176, 11'h078, 1'b1);
        idle_ticks(20);
        chk("ferr_count", done_count, 2);

        // back-to-back: 0x00 then 0xFF with no idle gap
        send_frame("b2b0", {1'b1, 1'b0, 8'h00, 1'b0}, 176, 11'h400, 1'b0);
        send_frame("b2b1", {1'b1, 1'b0, 8'hFF, 1'b0}, 176, 11'h5FE, 1'b0);
        idle_ticks(3);
        chk("b2b_count", done_count, 4);

        // reset in the middle of bit 4
        send_frame("abort", {1'b1, 1'b0, 8'h5A, 1'b0}, 16 * 4 + 6, 11'h000, 1'b0);
        chk("abort_active_pre", active_flag, 1'b1);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        chk("abort_active", active_flag, 1'b0);
        chk("abort_done", done_flag, 1'b0);
        chk("abort_data", data_parll, 11'h7FF);
        idle_ticks(200);
        chk("abort_count", done_count, 4);
        chk("abort_data_hold", data_parll, 11'h7FF);

        // frame after the abort: 0x5A
        send_frame("post", {1'b1, 1'b0, 8'h5A, 1'b0}, 176, 11'h4B4, 1'b0);
        idle_ticks(3);
        chk("post_count", done_count, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
